// File: rtl/audio_pkg.sv
// Constants and helpers shared by the EAR decode and speaker/mic encode paths.
package audio_pkg;
    localparam int unsigned AUDIO_DW = 16;
    localparam logic [AUDIO_DW-1:0] VOLUME = 16'h2000;
    localparam int unsigned SEXT_W = 64;

    typedef enum logic [1:0] {
        CAND_HOLD = 2'd0,
        CAND_HIGH = 2'd1,
        CAND_LOW  = 2'd2
    } cand_e;

    // Sign-extend the low w bits of x to SEXT_W bits; callers size-cast the result.
    function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] x,
                                                      input int unsigned w);
        logic signed [SEXT_W-1:0] t;
        t = $signed(x << (SEXT_W - w));
        return t >>> (SEXT_W - w);
    endfunction
endpackage

// File: rtl/dc_tracker.sv
// Leaky-integrator DC mean tracker; mean = acc >>> DC_SHIFT, frozen while en=0.
module dc_tracker #(
    parameter int unsigned AUDIO_DW = audio_pkg::AUDIO_DW,
    parameter int unsigned DC_SHIFT = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic signed [AUDIO_DW-1:0] in_data,
    output logic signed [AUDIO_DW-1:0] mean
);
    import audio_pkg::*;

    localparam int unsigned ACC_W = AUDIO_DW + DC_SHIFT;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [ACC_W-1:0] in_ext;

    // Shift kept in its own assignment so it stays arithmetic.
    always_comb begin
        acc_shr = acc_q >>> DC_SHIFT;
        in_ext  = $signed(ACC_W'(sext(SEXT_W'(in_data), AUDIO_DW)));
        acc_d   = acc_q;
        if (in_valid && en) begin
            acc_d = acc_q + in_ext - acc_shr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign mean = acc_q[ACC_W-1:DC_SHIFT];
endmodule

// File: rtl/ear_slicer.sv
// EAR level recovery: DC removal, hysteresis comparator and run-length glitch filter.
module ear_slicer #(
    parameter int unsigned          AUDIO_DW = audio_pkg::AUDIO_DW,
    parameter int unsigned          DC_SHIFT = 10,
    parameter logic [AUDIO_DW-1:0]  HYST     = 'h0400,
    parameter int unsigned          MIN_RUN  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       din_valid,
    input  logic signed [AUDIO_DW-1:0] din,
    input  logic                       dc_en,
    output logic                       dout,
    output logic                       dout_edge
);
    import audio_pkg::*;

    localparam int unsigned D_W   = AUDIO_DW + 1;
    localparam int unsigned CNT_W = $clog2(MIN_RUN + 1);
    localparam logic signed [D_W-1:0] HYST_P = $signed({1'b0, HYST});
    localparam logic signed [D_W-1:0] HYST_N = -HYST_P;
    localparam logic [CNT_W:0] MIN_RUN_W = (CNT_W + 1)'(MIN_RUN);

    logic signed [AUDIO_DW-1:0] s1_q, s1_d;
    logic signed [AUDIO_DW-1:0] mean;
    logic                       v1_q, v1_d;
    logic                       v2_q, v2_d;
    logic signed [D_W-1:0]      d2_q, d2_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CNT_W:0]             cnt_inc;
    logic                       dout_q, dout_d;
    logic                       dout_edge_q, dout_edge_d;
    cand_e                      cand;
    logic                       cand_bit;

    dc_tracker #(
        .AUDIO_DW (AUDIO_DW),
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_tracker (
        .clk      (clk),
        .reset    (reset),
        .en       (dc_en),
        .in_valid (v1_q),
        .in_data  (s1_q),
        .mean     (mean)
    );

    always_comb begin
        s1_d = din_valid ? din : s1_q;
        v1_d = din_valid;

        // Difference is one bit wider than the sample so rail inputs cannot wrap.
        v2_d = v1_q;
        d2_d = d2_q;
        if (v1_q) begin
            d2_d = $signed(D_W'(sext(SEXT_W'(s1_q), AUDIO_DW)))
                 - $signed(D_W'(sext(SEXT_W'(mean), AUDIO_DW)));
        end

        cand = CAND_HOLD;
        if (d2_q > HYST_P) begin
            cand = CAND_HIGH;
        end else if (d2_q < HYST_N) begin
            cand = CAND_LOW;
        end
        case (cand)
            CAND_HIGH: cand_bit = 1'b1;
            CAND_LOW:  cand_bit = 1'b0;
            default:   cand_bit = dout_q;
        endcase

        cnt_inc     = {1'b0, cnt_q} + 1'b1;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        dout_edge_d = 1'b0;
        if (v2_q) begin
            if (cand_bit == dout_q) begin
                cnt_d = '0;
            end else if (cnt_inc == MIN_RUN_W) begin
                dout_d      = cand_bit;
                dout_edge_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            d2_q        <= '0;
            cnt_q       <= '0;
            dout_q      <= 1'b0;
            dout_edge_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            d2_q        <= d2_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            dout_edge_q <= dout_edge_d;
        end
    end

    assign dout      = dout_q;
    assign dout_edge = dout_edge_q;
endmodule
